// File: rtl/benes_net_pipe_if.sv
// Handshake and data bundle for the pipelined Benes permutation network.
// The master side feeds control words and lane data; the slave side is the network.
interface benes_net_pipe_if #(
    parameter int SIZE   = 32,
    parameter int DWIDTH = 16
);
    localparam int TAGWIDTH = $clog2(SIZE);
    localparam int STAGES   = 2 * TAGWIDTH - 1;
    localparam int BITWIDTH = STAGES * SIZE / 2;

    logic [BITWIDTH-1:0] ctrl;
    logic                ctrl_valid;
    logic                ctrl_ready;
    logic                flush;
    logic [DWIDTH-1:0]   in_data [SIZE];
    logic                in_valid;
    logic                in_ready;
    logic [DWIDTH-1:0]   out_data [SIZE];
    logic                out_valid;
    logic                out_ready;
    logic                cfg_loaded;

    modport master (
        output ctrl, ctrl_valid, flush, in_data, in_valid, out_ready,
        input  ctrl_ready, in_ready, out_data, out_valid, cfg_loaded
    );

    modport slave (
        input  ctrl, ctrl_valid, flush, in_data, in_valid, out_ready,
        output ctrl_ready, in_ready, out_data, out_valid, cfg_loaded
    );
endinterface

// File: rtl/benes_net_pipe.sv
// Pipelined Benes network: one registered switch stage per column, lanes permuted
// by a held control word that is only replaced while the pipeline is empty.
module benes_net_pipe #(
    parameter int SIZE   = 32,
    parameter int DWIDTH = 16
) (
    input logic             clk,
    input logic             n_rst,
    benes_net_pipe_if.slave bus
);
    localparam int TAGWIDTH = $clog2(SIZE);
    localparam int STAGES   = 2 * TAGWIDTH - 1;
    localparam int HALF     = SIZE / 2;
    localparam int BITWIDTH = STAGES * HALF;

    logic [BITWIDTH-1:0] cfg_q, cfg_d;
    logic                cfg_loaded_q, cfg_loaded_d;
    logic [STAGES-1:0]   valid_q, valid_d;
    logic [DWIDTH-1:0]   lane_q [STAGES][SIZE];
    logic [DWIDTH-1:0]   lane_d [STAGES][SIZE];
    logic                adv;
    logic                in_ready;
    logic                ctrl_ready;

    // Each column pairs lanes gap apart; gap doubles toward the middle then halves.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int GAP = 1 << ((k < STAGES - 1 - k) ? k : STAGES - 1 - k);
        logic [DWIDTH-1:0] src [SIZE];

        if (k == 0) begin : g_first
            assign src = bus.in_data;
        end else begin : g_next
            assign src = lane_q[k-1];
        end

        for (genvar j = 0; j < HALF; j++) begin : g_sw
            localparam int POS = (j % GAP) + 2 * GAP * (j / GAP);
            localparam int BIT = k * HALF + j;
            assign lane_d[k][POS]     = cfg_q[BIT] ? src[POS+GAP] : src[POS];
            assign lane_d[k][POS+GAP] = cfg_q[BIT] ? src[POS]     : src[POS+GAP];
        end
    end

    assign adv        = !valid_q[STAGES-1] || bus.out_ready;
    assign ctrl_ready = ~|valid_q;
    // A pending control word starves the input so the pipe drains under the old cfg.
    assign in_ready   = adv && cfg_loaded_q && !bus.ctrl_valid;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        valid_d      = valid_q;
        cfg_d        = cfg_q;
        cfg_loaded_d = cfg_loaded_q;
        if (bus.flush) begin
            valid_d = '0;
        end else if (adv) begin
            valid_d = {valid_q[STAGES-2:0], bus.in_valid && in_ready};
        end
        if (bus.ctrl_valid && ctrl_ready) begin
            cfg_d        = bus.ctrl;
            cfg_loaded_d = 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments so all stages shift together.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_q      <= '0;
            cfg_q        <= '0;
            cfg_loaded_q <= 1'b0;
            // NOTE: the lane data array is cleared too, so outputs read zero in reset.
            for (int k = 0; k < STAGES; k++) begin
                for (int i = 0; i < SIZE; i++) begin
                    lane_q[k][i] <= '0;
                end
            end
        end else begin
            valid_q      <= valid_d;
            cfg_q        <= cfg_d;
            cfg_loaded_q <= cfg_loaded_d;
            if (adv) begin
                lane_q <= lane_d;
            end
        end
    end

    assign bus.out_data   = lane_q[STAGES-1];
    assign bus.out_valid  = valid_q[STAGES-1];
    assign bus.in_ready   = in_ready;
    assign bus.ctrl_ready = ctrl_ready;
    assign bus.cfg_loaded = cfg_loaded_q;
endmodule

// File: tb/tb_benes_net_pipe.sv
// Directed bench for benes_net_pipe: expected beats go into a scoreboard queue at
// acceptance and a negedge monitor pops and compares whatever the network emits.
module tb_benes_net_pipe;
    localparam int SIZE   = 32;
    localparam int DW     = 16;
    localparam int STAGES = 9;
    localparam int HALF   = SIZE / 2;
    localparam int BW     = STAGES * HALF;
    localparam int W      = SIZE * DW;

    typedef logic [W-1:0] flat_t;
    typedef struct {
        logic [STAGES-1:0] sel;
        int                mask;
    } vec_t;

    logic  clk = 1'b0;
    logic  n_rst = 1'b0;
    int    checks = 0;
    int    errors = 0;
    int    cycle = 0;
    int    or_mode = 0;
    flat_t sb [$];
    flat_t out_flat;

    benes_net_pipe_if #(.SIZE(SIZE), .DWIDTH(DW)) bus ();

    benes_net_pipe #(.SIZE(SIZE), .DWIDTH(DW)) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    always_comb begin
        out_flat = '0;
        for (int i = 0; i < SIZE; i++) out_flat[i*DW +: DW] = bus.out_data[i];
    end

    task automatic check(input string name, input flat_t act, input flat_t exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Input lane i carries base+i; a set of fully-set stages moves lane i^mask to lane i.
    function automatic flat_t expect_xor(input int base, input int mask);
        flat_t r;
        for (int i = 0; i < SIZE; i++) r[i*DW +: DW] = DW'(base + (i ^ mask));
        return r;
    endfunction

    function automatic logic [BW-1:0] stage_cfg(input logic [STAGES-1:0] sel);
        logic [BW-1:0] c;
        c = '0;
        for (int k = 0; k < STAGES; k++) if (sel[k]) c[k*HALF +: HALF] = '1;
        return c;
    endfunction

    task automatic drive_lanes(input int base);
        for (int i = 0; i < SIZE; i++) bus.in_data[i] = DW'(base + i);
    endtask

    task automatic tick(input int n);
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int base, input int mask);
        bit ok;
        ok = 1'b0;
        drive_lanes(base);
        bus.in_valid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (ok) sb.push_back(expect_xor(base, mask));
        else check_int("send_timeout", 0, 1);
    endtask

    task automatic send_stream(input int n, input int base, input int mask);
        for (int b = 0; b < n; b++) send(base + b * 64, mask);
        bus.in_valid = 1'b0;
    endtask

    task automatic load_ctrl(input logic [BW-1:0] c);
        bit ok;
        int leaked;
        int left;
        ok = 1'b0;
        leaked = 0;
        left = 0;
        bus.ctrl = c;
        bus.ctrl_valid = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (bus.in_ready) leaked++;
            if (bus.ctrl_ready) begin
                ok = 1'b1;
                left = sb.size();
            end
            @(posedge clk);
            #1;
        end
        bus.ctrl_valid = 1'b0;
        check_int("ctrl_accept", int'(ok), 1);
        check_int("in_ready_blocked", leaked, 0);
        check_int("drained_before_ctrl", left, 0);
        check_int("cfg_loaded", int'(bus.cfg_loaded), 1);
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && sb.size() > 0; t++) tick(1);
        check_int("drain", sb.size(), 0);
        tick(2);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        flat_t held;
        flat_t exp_v;
        bit    stalled;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) check("stall_hold", out_flat, held);
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %h expected none", out_flat);
                    end else begin
                        exp_v = sb.pop_front();
                        check("beat", out_flat, exp_v);
                    end
                end
                stalled = bus.out_valid && !bus.out_ready;
                held = out_flat;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        int   lat;
        int   c0;
        int   leaked;

        tbl[0] = '{9'b000000000, 0};
        tbl[1] = '{9'b000000001, 1};
        tbl[2] = '{9'b000010000, 16};
        tbl[3] = '{9'b100000001, 0};
        tbl[4] = '{9'b000010100, 20};
        tbl[5] = '{9'b000000010, 2};

        bus.ctrl = '0;
        bus.ctrl_valid = 1'b0;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        drive_lanes(0);

        // Reset state
        #12;
        check_int("rst_out_valid", int'(bus.out_valid), 0);
        check_int("rst_cfg_loaded", int'(bus.cfg_loaded), 0);
        check_int("rst_ctrl_ready", int'(bus.ctrl_ready), 1);
        check_int("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_data", out_flat, '0);
        n_rst = 1'b1;
        tick(1);

        // No data accepted before a control word arrives
        leaked = 0;
        drive_lanes(7);
        bus.in_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (bus.in_ready) leaked++;
            tick(1);
        end
        bus.in_valid = 1'b0;
        check_int("no_cfg_in_ready", leaked, 0);

        // Identity with latency measurement
        load_ctrl('0);
        send(0, 0);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            tick(1);
            lat++;
        end
        check_int("latency", lat, STAGES);
        drain();

        // Directed configurations
        for (int v = 0; v < 6; v++) begin
            load_ctrl(stage_cfg(tbl[v].sel));
            send_stream(2, 100 + v * 256, tbl[v].mask);
            drain();
        end

        // Back-to-back throughput under stage-0 swap
        load_ctrl(stage_cfg(9'b000000001));
        c0 = cycle;
        for (int b = 0; b < 4; b++) send(3000 + b * 64, 1);
        check_int("throughput", cycle - c0, 4);
        bus.in_valid = 1'b0;
        drain();

        // Backpressure with out_ready toggling
        or_mode = 1;
        send_stream(20, 5000, 1);
        drain();
        or_mode = 0;
        tick(2);

        // Control update with three beats in flight
        send_stream(3, 9000, 1);
        bus.ctrl = stage_cfg(9'b000010000);
        bus.ctrl_valid = 1'b1;
        drive_lanes(9500);
        bus.in_valid = 1'b1;
        @(negedge clk);
        check_int("upd_in_ready", int'(bus.in_ready), 0);
        check_int("upd_ctrl_ready", int'(bus.ctrl_ready), 0);
        tick(1);
        load_ctrl(stage_cfg(9'b000010000));
        send(9500, 16);
        bus.in_valid = 1'b0;
        drain();

        // Flush with five beats in flight plus a beat offered in the flush cycle
        send_stream(5, 12000, 16);
        bus.flush = 1'b1;
        drive_lanes(13000);
        bus.in_valid = 1'b1;
        tick(1);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        check_int("flush_out_valid", int'(bus.out_valid), 0);
        check_int("flush_empty", int'(bus.ctrl_ready), 1);
        check_int("flush_cfg_loaded", int'(bus.cfg_loaded), 1);
        sb.delete();
        tick(15);
        send(14000, 16);
        bus.in_valid = 1'b0;
        drain();

        // Asynchronous reset with a full, stalled pipeline
        or_mode = 2;
        send_stream(STAGES, 20000, 16);
        tick(2);
        check_int("full_out_valid", int'(bus.out_valid), 1);
        @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        check_int("mid_rst_out_valid", int'(bus.out_valid), 0);
        check_int("mid_rst_cfg_loaded", int'(bus.cfg_loaded), 0);
        check_int("mid_rst_in_ready", int'(bus.in_ready), 0);
        check_int("mid_rst_ctrl_ready", int'(bus.ctrl_ready), 1);
        check("mid_rst_out_data", out_flat, '0);
        sb.delete();
        or_mode = 0;
        @(negedge clk);
        #2;
        n_rst = 1'b1;
        tick(1);

        leaked = 0;
        drive_lanes(21000);
        bus.in_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (bus.in_ready) leaked++;
            tick(1);
        end
        bus.in_valid = 1'b0;
        check_int("post_rst_in_ready", leaked, 0);
        load_ctrl('0);
        send(22000, 0);
        bus.in_valid = 1'b0;
        drain();

        tick(5);
        check_int("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
